gray_ptr_sync: RTL and testbench
================================

Name: gray_ptr_sync

Overview:
Parametrised multi-channel synchroniser for gray-coded FIFO pointers, used in the destination clock domain of the async FIFO. Each channel passes through a configurable-depth flop chain. The block adds a registered gray-to-binary output, a fill-status flag, and a CDC-integrity checker. The checker flags any synchronised sample that differs from the previous one by more than one bit, which indicates a non-gray or multi-bit-skewed source.

Parameters:
depth, 1024, FIFO depth; pointer width AW = $clog2(depth)+1
stages, 2, synchroniser flop stages per channel; legal range 2..4
channels, 1, number of independent pointers synchronised; channel k occupies bits [k*AW +: AW]

Ports:
clk  input  1  destination-domain clock
rst  input  1  synchronous active-low reset
gin  input  channels*AW  asynchronous gray-coded pointers from the source domain
clr_err  input  1  synchronous clear of step_err and err_cnt
gout  output  channels*AW  synchronised gray pointers (last chain stage)
bout  output  channels*AW  binary equivalent of gout, registered
valid  output  1  high once the chains and checker history hold post-reset samples
step_err  output  channels  sticky per-channel multi-bit-step flag
err_cnt  output  8  saturating count of cycles with at least one channel violation

Behaviour:
- Reset: all logic is reset on posedge clk while rst==0. All chain flops, the previous-sample register, gout, bout, valid, step_err and err_cnt are set to 0. Reset asserted mid-operation aborts everything on the next edge. There is no partial state.
- Chain: per channel, s[0]<=gin, s[i]<=s[i-1], gout=s[stages-1]. gin-to-gout latency is exactly `stages` clocks. No reset synchroniser sits inside this block.
- Binary: bout<=gray2bin(gout), so latency from gin is stages+1. Conversion: b[AW-1]=g[AW-1], b[i]=b[i+1]^g[i].
- Fill counter: 3-bit counter, 0 after reset, increments each cycle up to stages+1 and then holds. valid = (cnt==stages+1).
- History: prev<=gout every cycle. Per-channel violation v[k] = valid && popcount(gout_k ^ prev_k) > 1.
  - A change of 0 or 1 bit is legal.
  - The wrap from the top pointer (gray of 2^AW-1) to 0 is a single-bit change and is legal.
- step_err[k]: set on the cycle after v[k]=1 and held until clr_err or reset.
- err_cnt: increments by 1 on any cycle where |v is 1, regardless of how many channels violate. Saturates at 255 with no wrap.
- clr_err=1: on the next edge, step_err<=v and err_cnt<=(|v ? 1 : 0). A violation arriving in the same cycle as the clear is never lost.
- clr_err has no effect on gout, bout or valid.
- Outputs are registered only; there is no combinational path from gin to any output.

Decomposition:
- Package gray_sync_pkg:
  - function gray2bin(AW-generic via parameterised width)
  - function multi_bit_diff (returns popcount>1)
  - localparam ERR_CNT_W=8
  - localparam ERR_CNT_MAX=255
- Sub-module gray_sync_chan: one instance per channel via generate.
  - Contains the chain, prev register, gray2bin register and the violation bit v.
- Top level holds the fill counter, valid, step_err, err_cnt and the clr_err logic.

Test Plan:
1. Reset: rst=0 for 3 clocks with gin=all-ones -> gout=bout=0, valid=0, step_err=0, err_cnt=0. After release (depth=16, stages=2), valid rises on the 3rd clock edge.
2. Latency: depth=16 (AW=5), stages=2, valid=1. Step gin 00010->00110 at edge n -> gout=00110 at edge n+2, bout=00100 (4) at edge n+3, step_err stays 0.
3. Sweep with wrap: gin steps through gray(0..31) then gray(0)=00000 after 10000 -> bout tracks 0..31,0 with stages+1 latency, step_err=0, err_cnt=0.
4. Violation: channels=2, channel 1 gin jumps 00000->00011, channel 0 steady -> step_err=2'b10 and err_cnt=1 at edge stages+1 after the jump. Both remain held for 20 quiet cycles.
5. Clear collision: with step_err=2'b10, pulse clr_err in the same cycle channel 0 shows a 2-bit step -> next edge step_err=2'b01, err_cnt=1.
6. Saturation and reset mid-run: toggle gin 00000<->00011 for 300 cycles -> err_cnt=255, held. Assert rst=0 for 1 clock -> every output is 0 on that edge and valid stays low until refill.

Source files
------------

// File: rtl/gray_sync_pkg.sv
// Shared helpers for the gray pointer synchroniser.
//   gray2bin       : gray to binary conversion on a MAX_AW-wide vector; callers
//                    zero-extend narrower pointers (leading zeros convert to zeros)
//   multi_bit_diff : 1 when two samples differ in more than one bit
//   ERR_CNT_W/MAX  : width and saturation value of the violation counter
package gray_sync_pkg;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;
  localparam int MAX_AW = 32;

  function automatic logic [MAX_AW-1:0] gray2bin(input logic [MAX_AW-1:0] g);
    logic [MAX_AW-1:0] b;
    b[MAX_AW-1] = g[MAX_AW-1];
    for (int i = MAX_AW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic multi_bit_diff(input logic [MAX_AW-1:0] a,
                                          input logic [MAX_AW-1:0] b);
    return $countones(a ^ b) > 1;
  endfunction

endpackage

// File: rtl/gray_sync_chan.sv
// One synchroniser channel: flop chain, previous-sample history, registered
// gray-to-binary output and the multi-bit-step violation flag.
//   clk, rst : destination clock, synchronous active-low reset
//   chk_en   : checker enable (chain and history hold post-reset samples)
//   gin      : asynchronous gray pointer from the source domain
//   gout     : last chain stage
//   bout     : registered binary of gout
//   viol     : gout differs from the previous sample in more than one bit
module gray_sync_chan
  import gray_sync_pkg::*;
#(
  parameter int AW     = 11,
  parameter int STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          chk_en,
  input  logic [AW-1:0] gin,
  output logic [AW-1:0] gout,
  output logic [AW-1:0] bout,
  output logic          viol
);

  logic [AW-1:0] sync_q [STAGES];
  logic [AW-1:0] sync_d [STAGES];
  logic [AW-1:0] prev_q, prev_d;
  logic [AW-1:0] bout_q, bout_d;

  always_comb begin
    sync_d[0] = gin;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[STAGES-1];
    bout_d = AW'(gray2bin(MAX_AW'(sync_q[STAGES-1])));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
      bout_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q <= prev_d;
      bout_q <= bout_d;
    end
  end

  assign gout = sync_q[STAGES-1];
  assign bout = bout_q;
  // A legal gray source never moves more than one bit between samples,
  // including the wrap from the top pointer back to zero.
  assign viol = chk_en && multi_bit_diff(MAX_AW'(sync_q[STAGES-1]), MAX_AW'(prev_q));

endmodule

// File: rtl/gray_ptr_sync.sv
// Multi-channel gray FIFO pointer synchroniser for the destination domain.
//   clk      : destination-domain clock
//   rst      : synchronous active-low reset
//   gin      : channels x AW asynchronous gray pointers, channel k at [k*AW +: AW]
//   clr_err  : synchronous clear of step_err and err_cnt
//   gout     : synchronised gray pointers
//   bout     : registered binary equivalent of gout
//   valid    : chains and checker history hold post-reset samples
//   step_err : sticky per-channel multi-bit-step flag
//   err_cnt  : saturating count of cycles with any channel violation
module gray_ptr_sync
  import gray_sync_pkg::*;
#(
  parameter int depth    = 1024,
  parameter int stages   = 2,
  parameter int channels = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [channels*($clog2(depth)+1)-1:0]   gin,
  input  logic                                    clr_err,
  output logic [channels*($clog2(depth)+1)-1:0]   gout,
  output logic [channels*($clog2(depth)+1)-1:0]   bout,
  output logic                                    valid,
  output logic [channels-1:0]                     step_err,
  output logic [ERR_CNT_W-1:0]                    err_cnt
);

  localparam int AW = $clog2(depth) + 1;
  // One extra fill cycle beyond the chain so the history register also
  // holds a post-reset sample before the checker is armed.
  localparam logic [2:0] FILL_MAX = 3'(stages + 1);

  logic [2:0]           fill_q, fill_d;
  logic [channels-1:0]  step_err_q, step_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [channels-1:0]  viol;
  logic                 viol_any;

  for (genvar k = 0; k < channels; k++) begin : g_chan
    gray_sync_chan #(
      .AW     (AW),
      .STAGES (stages)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .chk_en (valid),
      .gin    (gin[k*AW +: AW]),
      .gout   (gout[k*AW +: AW]),
      .bout   (bout[k*AW +: AW]),
      .viol   (viol[k])
    );
  end

  assign viol_any = |viol;
  assign valid    = (fill_q == FILL_MAX);

  always_comb begin
    fill_d = fill_q;
    if (fill_q != FILL_MAX) begin
      fill_d = fill_q + 3'd1;
    end

    // A violation in the clear cycle survives the clear.
    if (clr_err) begin
      step_err_d = viol;
      err_cnt_d  = {{(ERR_CNT_W-1){1'b0}}, viol_any};
    end else begin
      step_err_d = step_err_q | viol;
      err_cnt_d  = err_cnt_q;
      if (viol_any && (err_cnt_q != ERR_CNT_MAX)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fill_q     <= '0;
      step_err_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      fill_q     <= fill_d;
      step_err_q <= step_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign step_err = step_err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
module tb_gray_ptr_sync;

  localparam int DEPTH  = 16;
  localparam int STAGES = 2;
  localparam int CH     = 2;
  localparam int AW     = 5;
  localparam int W      = CH * AW;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] gin;
  logic         clr_err;
  logic [W-1:0] gout;
  logic [W-1:0] bout;
  logic         valid;
  logic [CH-1:0] step_err;
  logic [7:0]   err_cnt;

  always #5 clk = ~clk;

  gray_ptr_sync #(
    .depth    (DEPTH),
    .stages   (STAGES),
    .channels (CH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .gin      (gin),
    .clr_err  (clr_err),
    .gout     (gout),
    .bout     (bout),
    .valid    (valid),
    .step_err (step_err),
    .err_cnt  (err_cnt)
  );

  typedef struct {
    logic [W-1:0]  gout;
    logic [W-1:0]  bout;
    logic          valid;
    logic [CH-1:0] step;
    logic [7:0]    cnt;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] hist[$];
  int           age;
  logic [CH-1:0] m_step;
  int           m_cnt;
  int           total = 0;
  int           bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [4:0] gray(input int n);
    logic [4:0] v;
    v = 5'(n);
    return v ^ (v >> 1);
  endfunction

  // binary value of a gray code is the XOR of all its right shifts
  function automatic logic [W-1:0] g2b_vec(input logic [W-1:0] g);
    logic [W-1:0] r;
    logic [AW-1:0] c, b;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      c = g[k*AW +: AW];
      b = c;
      for (int s = 1; s < AW; s++) b = b ^ (c >> s);
      r[k*AW +: AW] = b;
    end
    return r;
  endfunction

  // One clock: drive inputs, predict outputs after the coming edge.
  task automatic step(input logic r, input logic c, input logic [W-1:0] g);
    exp_t e;
    logic [W-1:0] a, p;
    logic [CH-1:0] v;
    @(negedge clk);
    rst = r;
    clr_err = c;
    gin = g;
    hist.push_front(g);
    if (hist.size() > 8) void'(hist.pop_back());
    if (!r) begin
      age = 0;
      m_step = '0;
      m_cnt = 0;
    end else begin
      v = '0;
      if (age >= STAGES + 1) begin
        a = hist[STAGES];
        p = hist[STAGES+1];
        for (int k = 0; k < CH; k++)
          if ($countones(a[k*AW +: AW] ^ p[k*AW +: AW]) > 1) v[k] = 1'b1;
      end
      if (c) begin
        m_step = v;
        m_cnt = (v != 0) ? 1 : 0;
      end else begin
        m_step = m_step | v;
        if (v != 0 && m_cnt < 255) m_cnt++;
      end
      if (age < 100) age++;
    end
    e.valid = (age >= STAGES + 1);
    e.gout  = (age >= STAGES) ? hist[STAGES-1] : '0;
    e.bout  = (age >= STAGES + 1) ? g2b_vec(hist[STAGES]) : '0;
    e.step  = m_step;
    e.cnt   = 8'(m_cnt);
    sb.push_back(e);
    @(posedge clk);
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("gout", 32'(gout), 32'(e.gout));
      check("bout", 32'(bout), 32'(e.bout));
      check("valid", 32'(valid), 32'(e.valid));
      check("step_err", 32'(step_err), 32'(e.step));
      check("err_cnt", 32'(err_cnt), 32'(e.cnt));
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [W-1:0] g;
    int pos [CH];
    rst = 1'b0;
    clr_err = 1'b0;
    gin = '1;
    age = 0;
    m_step = '0;
    m_cnt = 0;
    for (int i = 0; i < 8; i++) hist.push_back('0);

    // reset with all-ones input, then release
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '1);
    #2;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_gout", 32'(gout), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '1);

    // latency: fresh reset at zero, then 00010 -> 00110 on channel 0
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'(5'b00010));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'(5'b00110));
    #2;
    check("lat_bout4", 32'(bout[AW-1:0]), 32'd4);

    // walk back to 0, then full sweep including the wrap
    for (int i = 3; i >= 0; i--) step(1'b1, 1'b0, W'(gray(i)));
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, W'(gray(i)));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, W'(gray(0)));
    #2;
    check("sweep_cnt", 32'(err_cnt), 32'd0);
    check("sweep_step", 32'(step_err), 32'd0);

    // channel 1 jumps by two bits
    g = '0;
    g[AW +: AW] = 5'b00011;
    for (int i = 0; i < 23; i++) step(1'b1, 1'b0, g);
    #2;
    check("viol_step", 32'(step_err), 32'b10);
    check("viol_cnt", 32'(err_cnt), 32'd1);

    // clear collides with a channel 0 violation
    g[AW-1:0] = 5'b00011;
    step(1'b1, 1'b0, g);
    step(1'b1, 1'b0, g);
    step(1'b1, 1'b1, g);
    #2;
    check("clr_step", 32'(step_err), 32'b01);
    check("clr_cnt", 32'(err_cnt), 32'd1);

    // saturation
    for (int i = 0; i < 300; i++) begin
      g[AW-1:0] = (i % 2 == 0) ? 5'b00000 : 5'b00011;
      step(1'b1, 1'b0, g);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, g);
    #2;
    check("sat_cnt", 32'(err_cnt), 32'd255);

    // reset mid-run
    step(1'b0, 1'b0, g);
    #2;
    check("midrst_cnt", 32'(err_cnt), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_bout", 32'(bout), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, g);

    // randomized traffic: mostly legal gray steps, occasional jumps/clears/resets
    for (int k = 0; k < CH; k++) pos[k] = (k == 0) ? 3 : 2;
    for (int i = 0; i < 400; i++) begin
      int r;
      for (int k = 0; k < CH; k++) begin
        r = $urandom_range(0, 99);
        if (r < 40) pos[k] = pos[k];
        else if (r < 70) pos[k] = (pos[k] + 1) % 32;
        else if (r < 95) pos[k] = (pos[k] + 31) % 32;
        else pos[k] = $urandom_range(0, 31);
        g[k*AW +: AW] = gray(pos[k]);
      end
      step(($urandom_range(0, 149) != 0), ($urandom_range(0, 19) == 0), g);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, g);
    @(posedge clk);
    #3;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
